// File: rtl/priority_bus_mux.sv
// Four-source fixed-priority bus multiplexer: the highest-index active request
// wins, and its index, data and a valid flag are presented one clock later.
module priority_bus_mux #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic [DATA_W-1:0] d3,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] data_out,
    output logic              valid
);

    logic [1:0]        sel_s;
    logic [DATA_W-1:0] data_s;
    logic              valid_s;

    logic [1:0]        sel_r;
    logic [DATA_W-1:0] data_r;
    logic              valid_r;

    // Fixed-priority encode of the request vector into a grant index.
    always_comb begin
        sel_s = 2'd0;
        if (req[3]) begin
            sel_s = 2'd3;
        end else if (req[2]) begin
            sel_s = 2'd2;
        end else if (req[1]) begin
            sel_s = 2'd1;
        end else begin
            sel_s = 2'd0;
        end
    end

    // Data steering; an idle bus drives zeros rather than forwarding d0.
    always_comb begin
        valid_s = |req;
        data_s  = {DATA_W{1'b0}};
        if (valid_s) begin
            case (sel_s)
                2'd0:    data_s = d0;
                2'd1:    data_s = d1;
                2'd2:    data_s = d2;
                2'd3:    data_s = d3;
                default: data_s = {DATA_W{1'b0}};
            endcase
        end else begin
            data_s = {DATA_W{1'b0}};
        end
    end

    // Output registers, the only state in the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r   <= 2'd0;
            data_r  <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
        end else begin
            sel_r   <= sel_s;
            data_r  <= data_s;
            valid_r <= valid_s;
        end
    end

    assign sel      = sel_r;
    assign data_out = data_r;
    assign valid    = valid_r;

endmodule

// File: tb/tb_priority_bus_mux.sv
// Directed bench for priority_bus_mux: a behavioural model checked every cycle
// plus literal expectations for the key scenarios.
module tb_priority_bus_mux;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        req = 4'b0000;
    logic [DATA_W-1:0] d0 = 8'hA1;
    logic [DATA_W-1:0] d1 = 8'hB2;
    logic [DATA_W-1:0] d2 = 8'hC3;
    logic [DATA_W-1:0] d3 = 8'hD4;
    logic [1:0]        sel;
    logic [DATA_W-1:0] data_out;
    logic              valid;

    int checks = 0;
    int errors = 0;

    logic [1:0]        exp_sel = 2'd0;
    logic [DATA_W-1:0] exp_data = '0;
    logic              exp_valid = 1'b0;

    priority_bus_mux #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .sel(sel), .data_out(data_out), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int top_index(input logic [3:0] r);
        for (int i = 3; i >= 0; i--) begin
            if (r[i]) return i;
        end
        return 0;
    endfunction

    // Behavioural model: highest set request bit wins, idle bus yields zeros.
    always @(posedge clk or negedge rst_n) begin
        logic [DATA_W-1:0] src [4];
        src[0] = d0; src[1] = d1; src[2] = d2; src[3] = d3;
        if (!rst_n) begin
            exp_sel   <= 2'd0;
            exp_data  <= '0;
            exp_valid <= 1'b0;
        end else if (req == 4'b0000) begin
            exp_sel   <= 2'd0;
            exp_data  <= '0;
            exp_valid <= 1'b0;
        end else begin
            exp_sel   <= 2'(top_index(req));
            exp_data  <= src[top_index(req)];
            exp_valid <= 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the clock edge.
    always @(posedge clk) begin
        #2;
        chk("model_sel", 32'(sel), 32'(exp_sel));
        chk("model_data", 32'(data_out), 32'(exp_data));
        chk("model_valid", 32'(valid), 32'(exp_valid));
    end

    task automatic apply(input logic [3:0] r, input logic [1:0] s, input logic [7:0] d,
                         input logic v, input string name);
        @(negedge clk);
        req = r;
        @(posedge clk);
        #1;
        chk({name, "_sel"}, 32'(sel), 32'(s));
        chk({name, "_data"}, 32'(data_out), 32'(d));
        chk({name, "_valid"}, 32'(valid), 32'(v));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        req = 4'b1111;
        #2;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_valid", 32'(valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b0000;

        apply(4'b0000, 2'd0, 8'h00, 1'b0, "idle");
        apply(4'b0001, 2'd0, 8'hA1, 1'b1, "req0001");
        apply(4'b0011, 2'd1, 8'hB2, 1'b1, "req0011");
        apply(4'b0101, 2'd2, 8'hC3, 1'b1, "req0101");
        apply(4'b1110, 2'd3, 8'hD4, 1'b1, "req1110");
        apply(4'b1000, 2'd3, 8'hD4, 1'b1, "req1000");
        apply(4'b0010, 2'd1, 8'hB2, 1'b1, "req0010");

        // Latency and hold: mid-cycle change of req must not show until the next edge.
        apply(4'b0001, 2'd0, 8'hA1, 1'b1, "pre_hold");
        @(negedge clk);
        req = 4'b1000;
        #2;
        chk("hold_sel", 32'(sel), 32'd0);
        chk("hold_data", 32'(data_out), 32'hA1);
        @(posedge clk);
        #1;
        chk("after_sel", 32'(sel), 32'd3);
        chk("after_data", 32'(data_out), 32'hD4);

        // Non-granted sources toggle every cycle; output must stay on d2.
        apply(4'b0100, 2'd2, 8'hC3, 1'b1, "iso_start");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            d0 = ~d0; d1 = ~d1; d3 = ~d3;
            @(posedge clk);
            #1;
            chk("iso_data", 32'(data_out), 32'hC3);
        end
        @(negedge clk);
        d0 = 8'hA1; d1 = 8'hB2; d3 = 8'hD4;

        // Simultaneous data and request change: values at the edge win.
        @(negedge clk);
        req = 4'b0010;
        d1 = 8'h5A;
        @(posedge clk);
        #1;
        chk("same_cycle_data", 32'(data_out), 32'h5A);
        chk("same_cycle_sel", 32'(sel), 32'd1);
        @(negedge clk);
        d1 = 8'hB2;

        // Reset asserted between edges clears outputs without a clock.
        apply(4'b1000, 2'd3, 8'hD4, 1'b1, "pre_reset");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_sel", 32'(sel), 32'd0);
        chk("midrst_data", 32'(data_out), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_sel", 32'(sel), 32'd3);
        chk("post_rst_data", 32'(data_out), 32'hD4);
        chk("post_rst_valid", 32'(valid), 32'd1);

        apply(4'b0000, 2'd0, 8'h00, 1'b0, "final_idle");
        repeat (2) @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
